// File: rtl/pdm_capture_ctrl.sv
// PDM microphone capture controller: sequences mic power-up and decimator reset,
// drops settling samples, then buffers decimator output in a 4-entry FIFO.
module pdm_capture_ctrl #(
    parameter int WAKE_CYCLES = 1024,
    parameter int DISCARD     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [2:0]         cfg_shift,
    input  logic [7:0]         cfg_alpha,
    output logic               mic_en,
    output logic               cic_rst,
    output logic [2:0]         cic_scale_shift,
    output logic [7:0]         cic_dc_alpha,
    input  logic signed [15:0] cic_pcm,
    input  logic               cic_pcm_valid,
    output logic signed [15:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               overflow,
    output logic [15:0]        sample_count
);

    typedef enum logic [1:0] {IDLE, WAKE, SETTLE, RUN} state_t;

    localparam logic [15:0] WAKE_LAST = 16'(WAKE_CYCLES - 1);
    localparam logic [3:0]  DISC_LAST = 4'(DISCARD - 1);

    state_t      state, state_nx;
    logic        accept_start;
    logic [15:0] wake_cnt;
    logic [3:0]  disc_cnt;

    logic signed [15:0] mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic        push, pop, full, wr_en;

    always_comb begin
        state_nx     = state;
        accept_start = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nx     = WAKE;
                    accept_start = 1'b1;
                end
            end
            WAKE: begin
                if (stop)
                    state_nx = IDLE;
                else if (wake_cnt == WAKE_LAST)
                    state_nx = (DISCARD > 0) ? SETTLE : RUN;
            end
            SETTLE: begin
                if (stop)
                    state_nx = IDLE;
                else if (cic_pcm_valid && disc_cnt == DISC_LAST)
                    state_nx = RUN;
            end
            RUN: begin
                if (stop)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output side is valid/ready: a sample leaves the FIFO on any edge where out_valid && out_ready.
    assign push      = (state == RUN) && cic_pcm_valid;
    assign pop       = out_valid && out_ready;
    assign full      = (count == 3'd4);
    assign wr_en     = push && (!full || pop);
    assign out_valid = (count != 3'd0);
    assign out_data  = mem[rd_ptr];
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            mic_en          <= 1'b0;
            cic_rst         <= 1'b1;
            cic_scale_shift <= 3'd0;
            cic_dc_alpha    <= 8'd0;
            overflow        <= 1'b0;
            sample_count    <= 16'd0;
            wake_cnt        <= 16'd0;
            disc_cnt        <= 4'd0;
            wr_ptr          <= 2'd0;
            rd_ptr          <= 2'd0;
            count           <= 3'd0;
            for (int i = 0; i < 4; i++)
                mem[i] <= 16'sd0;
        end else begin
            state   <= state_nx;
            // Driven from the next state so power/reset move on the same edge as the FSM.
            mic_en  <= (state_nx != IDLE);
            cic_rst <= (state_nx == IDLE) || (state_nx == WAKE);

            if (accept_start) begin
                cic_scale_shift <= cfg_shift;
                cic_dc_alpha    <= cfg_alpha;
                overflow        <= 1'b0;
                sample_count    <= 16'd0;
                wake_cnt        <= 16'd0;
                disc_cnt        <= 4'd0;
            end

            if (state == WAKE)
                wake_cnt <= wake_cnt + 16'd1;
            if (state == SETTLE && cic_pcm_valid)
                disc_cnt <= disc_cnt + 4'd1;

            if (wr_en) begin
                mem[wr_ptr]  <= cic_pcm;
                wr_ptr       <= wr_ptr + 2'd1;
                sample_count <= sample_count + 16'd1;
            end
            if (push && !wr_en)
                overflow <= 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;

            case ({wr_en, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Bench for pdm_capture_ctrl with WAKE_CYCLES=8, DISCARD=2: a vector table for the
// start-up sequence plus hand-written FIFO, stop and reset sequences.
module tb_pdm_capture_ctrl;

    logic               clk = 1'b0;
    logic               rst, start, stop, out_ready, cic_pcm_valid;
    logic [2:0]         cfg_shift;
    logic [7:0]         cfg_alpha;
    logic signed [15:0] cic_pcm;
    logic               mic_en, cic_rst, out_valid, busy, overflow;
    logic [2:0]         cic_scale_shift;
    logic [7:0]         cic_dc_alpha;
    logic signed [15:0] out_data;
    logic [15:0]        sample_count;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q [$];
    logic [15:0] exp_sc;

    typedef struct {
        logic        start, stop, pv;
        logic [15:0] pcm;
        logic        push;
        logic        exp_busy, exp_mic, exp_crst, exp_ov;
        logic [15:0] exp_cnt;
    } vec_t;
    vec_t tbl [13];

    pdm_capture_ctrl #(.WAKE_CYCLES(8), .DISCARD(2)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cfg_shift(cfg_shift), .cfg_alpha(cfg_alpha),
        .mic_en(mic_en), .cic_rst(cic_rst),
        .cic_scale_shift(cic_scale_shift), .cic_dc_alpha(cic_dc_alpha),
        .cic_pcm(cic_pcm), .cic_pcm_valid(cic_pcm_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .overflow(overflow), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [15:0] d, input logic accepted);
        cic_pcm       = d;
        cic_pcm_valid = 1'b1;
        if (accepted) exp_q.push_back(d);
        step();
        cic_pcm_valid = 1'b0;
    endtask

    task automatic pop_check(input string name);
        logic [15:0] e;
        check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_queue: got empty expected queue, required an entry", name);
        end else begin
            e = exp_q.pop_front();
            check({name, "_data"}, {16'd0, out_data}, {16'd0, e});
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic start_to_run(input logic [2:0] sh, input logic [7:0] al);
        cfg_shift = sh;
        cfg_alpha = al;
        start     = 1'b1;
        step();
        start = 1'b0;
        check("str_busy", {31'd0, busy}, 32'd1);
        repeat (8) step();
        check("str_cic_rst", {31'd0, cic_rst}, 32'd0);
        strobe(16'hdead, 1'b0);
        strobe(16'hbeef, 1'b0);
        exp_sc = 16'd0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
        cic_pcm_valid = 1'b0; cic_pcm = 16'sd0; cfg_shift = 3'd5; cfg_alpha = 8'd64;
        repeat (3) step();
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mic_en", {31'd0, mic_en}, 32'd0);
        check("rst_cic_rst", {31'd0, cic_rst}, 32'd1);
        check("rst_shift", {29'd0, cic_scale_shift}, 32'd0);
        check("rst_alpha", {24'd0, cic_dc_alpha}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_count", {16'd0, sample_count}, 32'd0);

        // start-up sequence: start, 8 wake cycles, two discarded strobes, one kept
        tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0};
        for (int i = 1; i < 8; i++)
            tbl[i] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 16'h0011, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 16'h0022, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 16'h0033, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};

        for (int i = 0; i < 13; i++) begin
            start = tbl[i].start;
            stop = tbl[i].stop;
            cic_pcm_valid = tbl[i].pv;
            cic_pcm = tbl[i].pcm;
            if (tbl[i].push) exp_q.push_back(tbl[i].pcm);
            step();
            start = 1'b0; stop = 1'b0; cic_pcm_valid = 1'b0;
            check($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].exp_busy});
            check($sformatf("tbl%0d_mic_en", i), {31'd0, mic_en}, {31'd0, tbl[i].exp_mic});
            check($sformatf("tbl%0d_cic_rst", i), {31'd0, cic_rst}, {31'd0, tbl[i].exp_crst});
            check($sformatf("tbl%0d_overflow", i), {31'd0, overflow}, {31'd0, tbl[i].exp_ov});
            check($sformatf("tbl%0d_count", i), {16'd0, sample_count}, {16'd0, tbl[i].exp_cnt});
            check($sformatf("tbl%0d_shift", i), {29'd0, cic_scale_shift}, 32'd5);
            check($sformatf("tbl%0d_alpha", i), {24'd0, cic_dc_alpha}, 32'd64);
            check($sformatf("tbl%0d_out_valid", i), {31'd0, out_valid},
                  {31'd0, exp_q.size() != 0});
        end

        // start while running is ignored, config holds
        cfg_shift = 3'd7; cfg_alpha = 8'd99; start = 1'b1;
        step();
        start = 1'b0;
        check("ign_start_shift", {29'd0, cic_scale_shift}, 32'd5);
        check("ign_start_alpha", {24'd0, cic_dc_alpha}, 32'd64);
        check("ign_start_busy", {31'd0, busy}, 32'd1);

        // stop: FIFO survives and pops in IDLE, config held across IDLE
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_busy", {31'd0, busy}, 32'd0);
        check("stop_mic_en", {31'd0, mic_en}, 32'd0);
        check("stop_cic_rst", {31'd0, cic_rst}, 32'd1);
        check("stop_shift", {29'd0, cic_scale_shift}, 32'd5);
        pop_check("idle_pop");
        check("idle_empty", {31'd0, out_valid}, 32'd0);

        // full FIFO with simultaneous push and pop
        start_to_run(3'd2, 8'd17);
        check("run2_shift", {29'd0, cic_scale_shift}, 32'd2);
        check("run2_alpha", {24'd0, cic_dc_alpha}, 32'd17);
        check("run2_count", {16'd0, sample_count}, 32'd0);
        for (int i = 0; i < 4; i++) strobe(16'($urandom_range(0, 65535)), 1'b1);
        exp_sc = 16'd4;
        cic_pcm = 16'($urandom_range(0, 65535));
        cic_pcm_valid = 1'b1;
        exp_q.push_back(cic_pcm);
        pop_check("full_pp");
        cic_pcm_valid = 1'b0;
        exp_sc = 16'd5;
        check("full_pp_overflow", {31'd0, overflow}, 32'd0);
        check("full_pp_count", {16'd0, sample_count}, {16'd0, exp_sc});
        for (int i = 0; i < 4; i++) pop_check("full_pp_drain");
        check("full_pp_empty", {31'd0, out_valid}, 32'd0);

        // overflow: 6 strobes, last 2 dropped
        for (int i = 0; i < 6; i++) strobe(16'($urandom_range(0, 65535)), i < 4);
        exp_sc = 16'd9;
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_count", {16'd0, sample_count}, {16'd0, exp_sc});
        for (int i = 0; i < 4; i++) pop_check("ovf_drain");
        check("ovf_empty", {31'd0, out_valid}, 32'd0);

        // start+stop together in RUN, with a strobe in the stop cycle
        strobe(16'h1234, 1'b1);
        start = 1'b1; stop = 1'b1;
        strobe(16'h5678, 1'b1);
        start = 1'b0; stop = 1'b0;
        exp_sc = 16'd11;
        check("ss_busy", {31'd0, busy}, 32'd0);
        check("ss_mic_en", {31'd0, mic_en}, 32'd0);
        check("ss_cic_rst", {31'd0, cic_rst}, 32'd1);
        check("ss_overflow", {31'd0, overflow}, 32'd1);
        check("ss_count", {16'd0, sample_count}, {16'd0, exp_sc});
        pop_check("ss_pop");

        // start does not flush; reset during WAKE clears everything
        cfg_shift = 3'd6; cfg_alpha = 8'd200; start = 1'b1;
        step();
        start = 1'b0;
        check("wk_not_flushed", {31'd0, out_valid}, 32'd1);
        check("wk_shift", {29'd0, cic_scale_shift}, 32'd6);
        repeat (3) step();
        rst = 1'b1; start = 1'b1; cic_pcm_valid = 1'b1;
        step();
        rst = 1'b0; start = 1'b0; cic_pcm_valid = 1'b0;
        exp_q.delete();
        check("wrst_busy", {31'd0, busy}, 32'd0);
        check("wrst_mic_en", {31'd0, mic_en}, 32'd0);
        check("wrst_cic_rst", {31'd0, cic_rst}, 32'd1);
        check("wrst_shift", {29'd0, cic_scale_shift}, 32'd0);
        check("wrst_alpha", {24'd0, cic_dc_alpha}, 32'd0);
        check("wrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("wrst_out_data", {16'd0, out_data}, 32'd0);
        check("wrst_overflow", {31'd0, overflow}, 32'd0);
        check("wrst_count", {16'd0, sample_count}, 32'd0);

        start = 1'b1;
        step();
        start = 1'b0;
        check("rw_mic_en", {31'd0, mic_en}, 32'd1);
        check("rw_cic_rst_0", {31'd0, cic_rst}, 32'd1);
        for (int k = 1; k < 8; k++) begin
            step();
            check($sformatf("rw_cic_rst_%0d", k), {31'd0, cic_rst}, 32'd1);
        end
        step();
        check("rw_cic_rst_rel", {31'd0, cic_rst}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
